burst_enable_gen: RTL
=====================

Name: burst_enable_gen

Overview:
Upstream stage for the 4-bit enable-gated counter. Generates that counter's `enable` strobe as a programmable train of bursts: N bursts of L consecutive enable cycles, separated by G idle cycles. Start/done handshake to the controlling sequencer; abort for early termination. The downstream count advances by exactly L*N (mod 16) per completed run.

Parameters:
LEN_W, 4, width of burst_len and gap_len
NB_W, 3, width of num_bursts

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a run; sampled only in IDLE
abort  input  1  synchronous cancel of an active run
burst_len  input  LEN_W  enable cycles per burst (L)
gap_len  input  LEN_W  idle cycles between bursts (G)
num_bursts  input  NB_W  bursts per run (N)
enable  output  1  strobe to downstream counter, registered
busy  output  1  high from accepted start until return to IDLE
done  output  1  one-cycle pulse on normal completion
burst_idx  output  NB_W  index of current burst, 0-based

Behaviour:
- Interface fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst high at an edge): state=IDLE; enable=0, busy=0, done=0, burst_idx=0; all internal counters cleared. rst overrides every other input, including mid-run.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, BURST, GAP, DONE.
- IDLE: start=1 at edge E → latch L, G, N. busy=1 from E+1. Inputs are ignored after latch.
  - L!=0 and N!=0 → BURST at E+1; enable=1 from cycle E+1.
  - L==0 or N==0 → DONE at E+1; enable never asserts.
- BURST: enable=1 for exactly L cycles. Last cycle of a burst:
  - If burst_idx==N-1 → DONE.
  - Else if G==0 → stay in BURST, burst_idx+1; enable stays high continuously.
  - Else → GAP; burst_idx+1.
- GAP: enable=0 for exactly G cycles, then BURST.
- DONE: done=1, enable=0, busy=0 for one cycle → IDLE. done never coincides with enable.
- burst_idx increments at the burst boundary and returns to 0 in IDLE/DONE.
- Total enable cycles per run = L*N; maximum 15*7=105.
- start while busy: ignored, with no queueing. start in the DONE cycle: ignored.
- abort=1 in BURST or GAP: IDLE next edge; enable=0, busy=0, burst_idx=0; no done pulse.
- abort in IDLE: no effect. abort and start in the same IDLE cycle: abort wins, so the run is not started.
- Counters use saturating-free modular arithmetic sized LEN_W/NB_W; the comparisons are against latched values only.

Optional Feature:
BURST_HOLD_EN
- Defined: adds input port `hold` (1 bit).
  - While hold=1 in BURST: enable=0 and the burst cycle counter freezes. The burst resumes where it left off when hold=0, so total enable cycles remain exactly L*N.
  - In GAP: the gap counter freezes.
  - In IDLE/DONE: no effect.
  - abort and rst override hold.
- Undefined: `hold` port absent; behaviour identical to hold tied 0.

Test Plan:
- rst mid-BURST (L=8, N=3, rst at 3rd enable cycle) → next cycle enable=0, busy=0, done=0, burst_idx=0; no done afterwards.
- start, L=3, G=2, N=2 → enable pattern from E+1: 1,1,1,0,0,1,1,1; then done=1 one cycle; burst_idx 0,0,0,1,1,1,1,1; downstream count 0→6.
- start, L=4, G=0, N=3 → enable high 12 consecutive cycles; burst_idx steps 0→1→2 every 4 cycles; done at cycle E+13; downstream count=12.
- start with L=0, N=5 → enable stays 0, done pulse at E+2, busy high exactly one cycle (E+1); start with N=0 gives the same result.
- L=15, G=1, N=2, abort on 5th enable cycle, start re-asserted during run → enable drops next cycle, no done, re-start ignored while busy; downstream count=5.
- (BURST_HOLD_EN) L=5, N=1, hold high for cycles 2-4 of burst → enable pattern 1,0,0,0,1,1,1,1; total 5 enables; done follows last enable.

Source files
------------

// File: rtl/burst_enable_gen_if.sv
// Sequencer-to-burst-generator bundle: run request/abort, burst shape, and the enable/status outputs.
// The optional hold input exists only when BURST_HOLD_EN is defined.
interface burst_enable_gen_if #(
   parameter int LEN_W = 4,
   parameter int NB_W  = 3
);
   logic             start;
   logic             abort;
   logic [LEN_W-1:0] burst_len;
   logic [LEN_W-1:0] gap_len;
   logic [NB_W-1:0]  num_bursts;
   logic             enable;
   logic             busy;
   logic             done;
   logic [NB_W-1:0]  burst_idx;
`ifdef BURST_HOLD_EN
   logic             hold;

   modport master (output start, abort, burst_len, gap_len, num_bursts, hold,
                   input  enable, busy, done, burst_idx);
   modport slave  (input  start, abort, burst_len, gap_len, num_bursts, hold,
                   output enable, busy, done, burst_idx);
`else
   modport master (output start, abort, burst_len, gap_len, num_bursts,
                   input  enable, busy, done, burst_idx);
   modport slave  (input  start, abort, burst_len, gap_len, num_bursts,
                   output enable, busy, done, burst_idx);
`endif
endinterface

// File: rtl/burst_enable_gen.sv
// Emits N bursts of L enable cycles separated by G idle cycles, with a start/done handshake and abort.
// All outputs registered; defining BURST_HOLD_EN adds a hold input that pauses burst/gap counting.
module burst_enable_gen #(
   parameter int LEN_W = 4,
   parameter int NB_W  = 3
) (
   input  logic                clk,
   input  logic                rst,
   burst_enable_gen_if.slave   bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BURST = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state;
   logic [LEN_W-1:0] len_q, gap_q, bcnt, gcnt;
   logic [NB_W-1:0]  nb_q, idx;
   logic             en_q, busy_q, done_q;
   logic             hold;
   logic             last_burst, burst_end, gap_end;

`ifdef BURST_HOLD_EN
   assign hold = bus.hold;
`else
   assign hold = 1'b0;
`endif

   // bcnt counts enable cycles issued in the current burst, including the one now on the output
   assign burst_end  = (bcnt == len_q);
   assign gap_end    = (gcnt == gap_q);
   assign last_burst = (idx == nb_q - NB_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         len_q  <= '0;
         gap_q  <= '0;
         nb_q   <= '0;
         bcnt   <= '0;
         gcnt   <= '0;
         idx    <= '0;
         en_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start && !bus.abort) begin
                  len_q  <= bus.burst_len;
                  gap_q  <= bus.gap_len;
                  nb_q   <= bus.num_bursts;
                  idx    <= '0;
                  busy_q <= 1'b1;
                  if (bus.burst_len != '0 && bus.num_bursts != '0) begin
                     state <= S_BURST;
                     en_q  <= 1'b1;
                     bcnt  <= LEN_W'(1);
                  end else begin
                     state <= S_DONE;
                  end
               end
            end
            S_BURST: begin
               if (bus.abort) begin
                  state  <= S_IDLE;
                  en_q   <= 1'b0;
                  busy_q <= 1'b0;
                  idx    <= '0;
               end else if (burst_end) begin
                  if (last_burst) begin
                     state  <= S_DONE;
                     en_q   <= 1'b0;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     idx    <= '0;
                  end else begin
                     idx <= idx + NB_W'(1);
                     if (gap_q == '0) begin
                        en_q <= !hold;
                        bcnt <= hold ? '0 : LEN_W'(1);
                     end else begin
                        state <= S_GAP;
                        en_q  <= 1'b0;
                        gcnt  <= LEN_W'(1);
                     end
                  end
               end else if (hold) begin
                  en_q <= 1'b0;
               end else begin
                  en_q <= 1'b1;
                  bcnt <= bcnt + LEN_W'(1);
               end
            end
            S_GAP: begin
               if (bus.abort) begin
                  state  <= S_IDLE;
                  en_q   <= 1'b0;
                  busy_q <= 1'b0;
                  idx    <= '0;
               end else if (!hold) begin
                  if (gap_end) begin
                     state <= S_BURST;
                     en_q  <= 1'b1;
                     bcnt  <= LEN_W'(1);
                  end else begin
                     gcnt <= gcnt + LEN_W'(1);
                  end
               end
            end
            S_DONE: begin
               // An empty run arrives here with busy still high and done not yet shown
               if (!done_q) begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
               end else begin
                  done_q <= 1'b0;
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.enable    = en_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.burst_idx = idx;
endmodule
